// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a client and the serial adder.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell shared by the serial adder.
module Full_adder (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = A ^ B ^ cin;
    assign cout = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one Full_adder cell reused over WIDTH cycles, LSB first.
// {cout,sum} = a + b + cin, valid from the done pulse until the next accepted start.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    count;
    logic             carry;
    logic             cout_r;
    logic             done_r;
    logic             cell_sum;
    logic             cell_cout;

    Full_adder u_cell (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // IDLE and DONE both accept a new start; start during RUN is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            count  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                RUN: begin
                    sum_r <= {cell_sum, sum_r[WIDTH-1:1]};
                    carry <= cell_cout;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        cout_r <= cell_cout;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= bus.cin;
                        count  <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that reuses a single full-adder cell over WIDTH clock cycles, trading latency for area. It sits directly upstream of the full-adder cell. It latches two operands and a carry-in, presents one LSB-first bit pair plus the registered carry to the cell each cycle, and shifts the cell's sum bit into a result register. It is the sequential wrapper the team uses wherever a narrow single-cell adder is preferred over a ripple array.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to begin an addition; sampled on rising clk
- a  input  WIDTH  operand A; sampled only when start is accepted
- b  input  WIDTH  operand B; sampled only when start is accepted
- cin  input  1  carry-in; sampled only when start is accepted
- busy  output  1  high while a serial addition is in progress
- done  output  1  one-cycle pulse; sum and cout are valid
- sum  output  WIDTH  result bits, held until the next accepted start
- cout  output  1  final carry-out, held with sum

## Operation
- Reset is asynchronous and active-low: one clock; asserting rst_n=0 at any time forces state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers/carry/counter=0.
- States:
  - IDLE: waiting for start.
  - RUN: adding bit k = 0..WIDTH-1, one bit per cycle.
  - DONE: one cycle; done=1.
- start is accepted when state is IDLE or DONE. On acceptance: a_sh<=a, b_sh<=b, carry<=cin, count<=0, sum<=0, cout<=0, state<=RUN.
- start while in RUN is ignored; operands and ongoing computation are unaffected.
- Each RUN cycle:
  - The cell sees a_sh[0], b_sh[0], carry.
  - sum shifts right with the cell's sum bit entering at MSB.
  - carry<=cell cout; a_sh and b_sh shift right; count increments.
- When count==WIDTH-1 in RUN, the cycle finishes the last bit, then cout<=cell cout and state<=DONE.
- DONE: done=1 for exactly one cycle. Without start it goes to IDLE. With start it accepts new operands and goes to RUN; done still pulses in that cycle.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Outputs are registered and glitch-free. busy is decoded from state (state==RUN).
- sum is not guaranteed meaningful while busy=1 (partial shift). It is valid from done onward until the next accepted start.

## Timing
- Start accepted at edge T0: busy=1 from T0 through edge T0+WIDTH.
- done=1 after edge T0+WIDTH for one cycle. Latency from start sample to done is WIDTH+1 cycles (9 for WIDTH=8).
- Back-to-back throughput is one result per WIDTH+1 cycles.
- Reset mid-RUN aborts with no done pulse. The first start after rst_n deasserts is accepted on the first rising edge where start=1.
- Synchronous deassertion of rst_n is the integrator's responsibility.

## Structure
- Shared package: the state encoding constants IDLE/RUN/DONE (2-bit), and the default width constant.
- Counter width: $clog2(WIDTH), computed locally.
- One sub-module: the existing Full_adder cell (ports A, B, cin, sum, cout), instantiated exactly once. The block adds no other combinational add logic.

## Test plan
- WIDTH=8, a=0x3C, b=0x42, cin=0, pulse start -> busy high 8 cycles; done at cycle 9; sum=0x7E, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, done exactly once.
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1 (full carry ripple through all 8 bits).
- Start a=0x10, b=0x20; re-assert start with a=0xFF, b=0xFF at RUN cycle 3 -> second start ignored; result sum=0x30, cout=0.
- Start a=0x0F, b=0x01, then drive rst_n=0 at RUN cycle 4 -> busy, done, sum, cout all 0 immediately, with no done pulse afterwards. A following start a=0x01, b=0x01 -> sum=0x02.
- Hold start=1 continuously with new operands each done cycle, 100 random vectors -> each result matches a+b+cin; done spacing is exactly 9 cycles; busy is low only during done cycles.
